// File: rtl/spi_tx_pkg.sv
// Shared definitions for the SPI transmit peripheral: bus register map,
// STATUS bit layout, word-length encodings and the shifter state type.
package spi_tx_pkg;

    localparam logic [1:0] ADDR_TXDATA = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    localparam int ST_XMIT    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_LVL_LSB = 4;

    // Writing STATUS with this bit set clears the sticky overflow flag
    localparam int ST_OVF_CLR = 3;

    localparam logic [1:0] LEN_8  = 2'd0;
    localparam logic [1:0] LEN_16 = 2'd1;
    localparam logic [1:0] LEN_32 = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        TAIL,
        GAP
    } spi_state_t;

    // Index of the first (most significant) bit sent for a length encoding
    function automatic logic [4:0] len_msb(input logic [1:0] enc);
        case (enc)
            LEN_8:   return 5'd7;
            LEN_16:  return 5'd15;
            default: return 5'd31;
        endcase
    endfunction

endpackage

// File: rtl/spi_tx_fifo.sv
// Synchronous FIFO with first-word-fall-through read; the head word is
// visible on rdata whenever empty is low. Caller never pops when empty.
module spi_tx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign level = count;

endmodule

// File: rtl/spi_tx_periph.sv
// Memory-mapped SPI mode-0 master transmitter: CPU stores fill a TX FIFO,
// words are shifted out MSB-first, one slave-select pulse per word.
//
//   state | meaning
//   IDLE  | waiting for a FIFO word while hold is clear; pops on exit
//   LOAD  | latch length, drop cs_spi_n, present first bit
//   SHIFT | clk_spi toggles every CLK_DIV cycles; bits change on falling
//   TAIL  | final falling edge, then a low half-period before cs_spi_n rises
//   GAP   | cs_spi_n high for one half-period before the next word
module spi_tx_periph
    import spi_tx_pkg::*;
#(
    parameter int CLK_DIV    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        clk_spi,
    output logic        tx_spi,
    output logic        cs_spi_n,
    output logic        busy
);

    localparam logic [7:0] CNT_TC = 8'(CLK_DIV - 1);

    spi_state_t state;
    logic [2:0]  ctrl;
    logic        overflow;
    logic [31:0] shreg;
    logic [4:0]  bit_count;
    logic [7:0]  cont;
    logic        transmitting;

    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] fifo_rdata;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;

    logic        push;
    logic        pop;
    logic        push_ok;
    logic        cont_tc;
    logic [4:0]  load_msb;
    logic [31:0] status_word;

    assign push     = sel && we && (addr == ADDR_TXDATA);
    assign pop      = (state == IDLE) && !fifo_empty && !ctrl[2];
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
    assign push_ok  = push && (!fifo_full || pop);
    assign cont_tc  = (cont == CNT_TC);
    assign load_msb = len_msb(ctrl[1:0]);

    always_comb begin
        status_word = '0;
        status_word[ST_LVL_LSB +: 4] = 4'(fifo_level);
        status_word[ST_OVF]          = overflow;
        status_word[ST_EMPTY]        = fifo_empty;
        status_word[ST_FULL]         = fifo_full;
        status_word[ST_XMIT]         = transmitting;
    end

    // LOAD is included so busy does not dip between the pop and transmitting rising
    assign busy = transmitting || !fifo_empty || (state == LOAD);

    spi_tx_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_ok),
        .pop   (pop),
        .wdata (wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl     <= '0;
            overflow <= 1'b0;
            rdata    <= '0;
        end else begin
            if (sel && we) begin
                case (addr)
                    ADDR_TXDATA: if (fifo_full && !pop) overflow <= 1'b1;
                    ADDR_STATUS: if (wdata[ST_OVF_CLR]) overflow <= 1'b0;
                    ADDR_CTRL:   ctrl <= wdata[2:0];
                    default:     ;
                endcase
            end
            if (sel && !we) begin
                case (addr)
                    ADDR_TXDATA: rdata <= '0;
                    ADDR_STATUS: rdata <= status_word;
                    ADDR_CTRL:   rdata <= {29'b0, ctrl};
                    default:     rdata <= rdata;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            shreg        <= '0;
            bit_count    <= '0;
            cont         <= '0;
            clk_spi      <= 1'b0;
            tx_spi       <= 1'b0;
            cs_spi_n     <= 1'b1;
            transmitting <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cont <= '0;
                    if (pop) begin
                        shreg <= fifo_rdata;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    cs_spi_n     <= 1'b0;
                    tx_spi       <= shreg[load_msb];
                    bit_count    <= load_msb;
                    cont         <= '0;
                    clk_spi      <= 1'b0;
                    transmitting <= 1'b1;
                    state        <= SHIFT;
                end
                SHIFT: begin
                    if (cont_tc) begin
                        cont    <= '0;
                        clk_spi <= ~clk_spi;
                        if (!clk_spi) begin
                            if (bit_count == '0) begin
                                state <= TAIL;
                            end
                        end else begin
                            bit_count <= bit_count - 5'd1;
                            tx_spi    <= shreg[bit_count - 5'd1];
                        end
                    end else begin
                        cont <= cont + 8'd1;
                    end
                end
                TAIL: begin
                    if (cont_tc) begin
                        cont <= '0;
                        if (clk_spi) begin
                            clk_spi <= 1'b0;
                        end else begin
                            cs_spi_n <= 1'b1;
                            state    <= GAP;
                        end
                    end else begin
                        cont <= cont + 8'd1;
                    end
                end
                GAP: begin
                    if (cont_tc) begin
                        cont         <= '0;
                        transmitting <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        cont <= cont + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
